// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage: evaluates condition codes against the architectural NZCV
// register and buffers results in a 2-entry FIFO toward the register-file write port.
module alu_writeback_stage #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] alu_out,
  input  logic [3:0]   alu_flag,
  input  logic [3:0]   rd,
  input  logic [3:0]   cond,
  input  logic         set_flags,
  input  logic         wr_req,
  input  logic         flush,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic [N-1:0] wb_data,
  output logic [3:0]   wb_rd,
  output logic         wb_we,
  output logic [3:0]   nzcv,
  output logic         cond_pass
);

  typedef struct packed {
    logic [N-1:0] data;
    logic [3:0]   rd;
    logic         we;
  } entry_t;

  entry_t     mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q;
  logic [3:0] nzcv_q;
  logic       push, pop;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign flag_n = nzcv_q[3];
  assign flag_z = nzcv_q[2];
  assign flag_c = nzcv_q[1];
  assign flag_v = nzcv_q[0];

  // Evaluated on the registered flags so a dependent op right behind a flag-setter sees its result.
  always_comb begin
    cond_pass = 1'b1;
    case (cond)
      4'h0:    cond_pass = flag_z;
      4'h1:    cond_pass = !flag_z;
      4'h2:    cond_pass = flag_c;
      4'h3:    cond_pass = !flag_c;
      4'h4:    cond_pass = flag_n;
      4'h5:    cond_pass = !flag_n;
      4'h6:    cond_pass = flag_v;
      4'h7:    cond_pass = !flag_v;
      4'h8:    cond_pass = flag_c && !flag_z;
      4'h9:    cond_pass = !flag_c || flag_z;
      4'hA:    cond_pass = (flag_n == flag_v);
      4'hB:    cond_pass = (flag_n != flag_v);
      4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
      4'hD:    cond_pass = flag_z || (flag_n != flag_v);
      default: cond_pass = 1'b1;
    endcase
  end

  // in_ready is purely registered; no path from wb_ready.
  assign in_ready = (count_q != 2'd2);
  assign wb_valid = (count_q != 2'd0);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = wb_valid && wb_ready;

  assign wb_data = mem_q[rd_ptr_q].data;
  assign wb_rd   = mem_q[rd_ptr_q].rd;
  assign wb_we   = mem_q[rd_ptr_q].we;
  assign nzcv    = nzcv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      nzcv_q   <= 4'b0000;
    end else if (flush) begin
      // Entries are zeroed so the write port shows zeros, not stale data, after a flush.
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{data: alu_out, rd: rd, we: wr_req && cond_pass};
        wr_ptr_q        <= ~wr_ptr_q;
        if (set_flags && cond_pass) nzcv_q <= alu_flag;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: reset, flag chaining, backpressure,
// signed conditions, flush and asynchronous reset.
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_out;
  logic [3:0]  alu_flag;
  logic [3:0]  rd;
  logic [3:0]  cond;
  logic        set_flags;
  logic        wr_req;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_we;
  logic [3:0]  nzcv;
  logic        cond_pass;

  int errors = 0;
  int checks = 0;

  alu_writeback_stage #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .alu_flag  (alu_flag),
    .rd        (rd),
    .cond      (cond),
    .set_flags (set_flags),
    .wr_req    (wr_req),
    .flush     (flush),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd),
    .wb_we     (wb_we),
    .nzcv      (nzcv),
    .cond_pass (cond_pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] r, input logic [3:0] c,
                       input logic w, input logic s, input logic [3:0] f);
    in_valid  = 1'b1;
    alu_out   = d;
    rd        = r;
    cond      = c;
    wr_req    = w;
    set_flags = s;
    alu_flag  = f;
  endtask

  task automatic set_flags_to(input logic [3:0] f);
    drive(32'h0, 4'h0, 4'hE, 1'b0, 1'b1, f);
    tick();
    in_valid  = 1'b0;
    set_flags = 1'b0;
  endtask

  task automatic chk_cond(input string tag, input logic [3:0] c, input logic exp);
    cond = c;
    #1;
    chk(tag, {31'b0, cond_pass}, {31'b0, exp});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b0; flush = 1'b0;
    alu_out = '0; alu_flag = '0; rd = '0; cond = 4'hE; set_flags = 1'b0; wr_req = 1'b0;
    #3;
    chk("rst_nzcv", nzcv, 4'b0000);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_data", wb_data, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // First transaction, one-cycle latency
    drive(32'd5, 4'd3, 4'hE, 1'b1, 1'b0, 4'b0000);
    tick();
    in_valid = 1'b0;
    chk("first_valid", wb_valid, 1);
    chk("first_data", wb_data, 5);
    chk("first_rd", wb_rd, 3);
    chk("first_we", wb_we, 1);
    wb_ready = 1'b1;
    tick();
    chk("first_popped", wb_valid, 0);

    // Flag chain with back-to-back dependency
    drive(32'd0, 4'd1, 4'hE, 1'b1, 1'b1, 4'b0100);
    tick();
    chk("chain_nzcv", nzcv, 4'b0100);
    chk("chain_e1_data", wb_data, 0);
    drive(32'd7, 4'd2, 4'h0, 1'b1, 1'b0, 4'b0000);
    #1;
    chk("chain_eq_pass", cond_pass, 1);
    tick();
    chk("chain_eq_data", wb_data, 7);
    chk("chain_eq_we", wb_we, 1);
    drive(32'd8, 4'd2, 4'h1, 1'b1, 1'b0, 4'b0000);
    tick();
    chk("chain_ne_valid", wb_valid, 1);
    chk("chain_ne_data", wb_data, 8);
    chk("chain_ne_we", wb_we, 0);

    // Failed condition must not update flags
    drive(32'd9, 4'd4, 4'h1, 1'b1, 1'b1, 4'b1000);
    tick();
    in_valid = 1'b0;
    chk("nofl_nzcv", nzcv, 4'b0100);
    chk("nofl_data", wb_data, 9);
    chk("nofl_we", wb_we, 0);
    tick();
    chk("nofl_drained", wb_valid, 0);

    // Backpressure: only 1 and 2 fit
    wb_ready = 1'b0;
    drive(32'd1, 4'd1, 4'hE, 1'b1, 1'b0, 4'b0000);
    #1; chk("bp_rdy1", in_ready, 1);
    tick();
    alu_out = 32'd2;
    chk("bp_rdy2", in_ready, 1);
    tick();
    alu_out = 32'd3;
    chk("bp_rdy3", in_ready, 0);
    tick();
    alu_out = 32'd4;
    chk("bp_rdy4", in_ready, 0);
    tick();
    chk("bp_head", wb_data, 1);
    // Upstream retries 3 then 4 once space frees
    wb_ready = 1'b1;
    alu_out  = 32'd3;
    chk("bp_full_rdy", in_ready, 0);
    tick();
    chk("bp_out2", wb_data, 2);
    chk("bp_rdy_back", in_ready, 1);
    tick();
    alu_out = 32'd4;
    chk("bp_out3", wb_data, 3);
    tick();
    in_valid = 1'b0;
    chk("bp_out4", wb_data, 4);
    tick();
    chk("bp_empty", wb_valid, 0);

    // Signed and unsigned compound conditions
    set_flags_to(4'b1001);
    chk("sc_nzcv_1001", nzcv, 4'b1001);
    chk_cond("ge_1001", 4'hA, 1'b1);
    chk_cond("lt_1001", 4'hB, 1'b0);
    set_flags_to(4'b1000);
    chk_cond("lt_1000", 4'hB, 1'b1);
    chk_cond("gt_1000", 4'hC, 1'b0);
    chk_cond("le_1000", 4'hD, 1'b1);
    chk_cond("mi_1000", 4'h4, 1'b1);
    set_flags_to(4'b0010);
    chk_cond("hi_0010", 4'h8, 1'b1);
    chk_cond("cc_0010", 4'h3, 1'b0);
    set_flags_to(4'b0110);
    chk_cond("ls_0110", 4'h9, 1'b1);
    chk_cond("hi_0110", 4'h8, 1'b0);
    chk_cond("al_0110", 4'hF, 1'b1);
    tick();

    // Flush with two entries held and a coincident flag-setting input
    wb_ready = 1'b0;
    drive(32'd11, 4'd5, 4'hE, 1'b1, 1'b0, 4'b0000);
    tick();
    alu_out = 32'd12;
    tick();
    chk("fl_full", in_ready, 0);
    drive(32'd13, 4'd6, 4'hE, 1'b1, 1'b1, 4'b1111);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", wb_valid, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_nzcv", nzcv, 4'b0110);
    chk("fl_data", wb_data, 0);

    // Asynchronous reset mid-stream
    drive(32'd21, 4'd7, 4'hE, 1'b1, 1'b1, 4'b0011);
    tick();
    in_valid = 1'b0;
    chk("ar_pre_valid", wb_valid, 1);
    chk("ar_pre_nzcv", nzcv, 4'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", wb_valid, 0);
    chk("ar_nzcv", nzcv, 4'b0000);
    chk("ar_ready", in_ready, 1);
    chk("ar_data", wb_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
